// File: rtl/plot_scheduler_pkg.sv
// plot_pkg: shared definitions for the plot scheduler.
//   state_t  - scheduler state encoding (IDLE / BOX / CLEAR)
//   SCREEN_W, SCREEN_H - vga_adapter frame size in pixels
//   X_W, Y_W, C_W      - widths of the x, y and colour buses
package plot_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BOX   = 2'd1,
        CLEAR = 2'd2
    } state_t;
endpackage

// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if: box-command bus between the game logic and the scheduler.
//   req_valid  - per-requester command valid, held until acked
//   req_x/y    - packed box top-left corners, slot i at [X_W*i +: X_W] / [Y_W*i +: Y_W]
//   req_colour - packed box colours, slot i at [C_W*i +: C_W]
//   req_fill   - 1 = filled box, 0 = outline
//   req_ack    - one-cycle pulse when a command is latched
//   req_done   - one-cycle pulse with the last pixel of a box
// Modports: master = requester side, slave = scheduler side.
interface plot_scheduler_if
    import plot_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*X_W-1:0] req_x;
    logic [NUM_REQ*Y_W-1:0] req_y;
    logic [NUM_REQ*C_W-1:0] req_colour;
    logic [NUM_REQ-1:0]     req_fill;
    logic [NUM_REQ-1:0]     req_ack;
    logic [NUM_REQ-1:0]     req_done;

    modport master (
        output req_valid, req_x, req_y, req_colour, req_fill,
        input  req_ack, req_done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_colour, req_fill,
        output req_ack, req_done
    );
endinterface

// File: rtl/plot_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   ptr     - index with highest priority this cycle; search goes upward with wrap
//   grant   - one-hot grant (zero when no request)
//   idx     - binary index of the granted bit
//   any_req - at least one request is set
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);
    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler: shares the vga_adapter plot port between NUM_REQ box
// requesters and a full-screen clear.
//   clock, reset - system clock; synchronous active-low reset
//   req          - box-command bus (slave side)
//   clear_req    - full-screen clear request (level or pulse)
//   x, y, colour, plot - registered pixel write to vga_adapter
//   busy         - high whenever the scheduler is not idle
// A box is swept column-first from its latched corner, one pixel per clock;
// a clear sweeps the whole frame to BG_COLOUR and has priority over boxes.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int             NUM_REQ   = 4,
    parameter int             BOX_W     = 4,
    parameter int             BOX_H     = 4,
    parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic            clock,
    input  logic            reset,
    plot_scheduler_if.slave req,
    input  logic            clear_req,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic [C_W-1:0]  colour,
    output logic            plot,
    output logic            busy
);
    localparam int             IDX_W    = $clog2(NUM_REQ);
    localparam logic [X_W-1:0] COL_LAST = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(BOX_H - 1);
    localparam logic [X_W-1:0] X_LAST   = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(SCREEN_H - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n, owner, owner_n;
    logic               pend, pend_n;
    // cnt_x/cnt_y are the box col/row offsets in BOX and the frame position in CLEAR
    logic [X_W-1:0]     cnt_x, cnt_x_n, bx, bx_n;
    logic [Y_W-1:0]     cnt_y, cnt_y_n, by, by_n;
    logic [C_W-1:0]     bcol, bcol_n;
    logic               bfill, bfill_n;
    logic [X_W-1:0]     x_n;
    logic [Y_W-1:0]     y_n;
    logic [C_W-1:0]     colour_n;
    logic               plot_n, busy_n;
    logic [NUM_REQ-1:0] ack, ack_n, done, done_n;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gidx;
    logic               any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req.req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .idx     (gidx),
        .any_req (any_req)
    );

    // Pixel position with one spare bit so off-screen pixels are detected
    // instead of wrapping back onto the screen.
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    logic         clipped, border;

    assign sx      = {1'b0, bx} + {1'b0, cnt_x};
    assign sy      = {1'b0, by} + {1'b0, cnt_y};
    assign clipped = (sx >= (X_W+1)'(SCREEN_W)) || (sy >= (Y_W+1)'(SCREEN_H));
    assign border  = (cnt_x == '0) || (cnt_x == COL_LAST) ||
                     (cnt_y == '0) || (cnt_y == ROW_LAST);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        pend_n   = pend;
        cnt_x_n  = cnt_x;
        cnt_y_n  = cnt_y;
        bx_n     = bx;
        by_n     = by;
        bcol_n   = bcol;
        bfill_n  = bfill;
        x_n      = x;
        y_n      = y;
        colour_n = colour;
        plot_n   = 1'b0;
        ack_n    = '0;
        done_n   = '0;

        case (state)
            IDLE: begin
                // A clear arriving in the same cycle as a box request wins.
                if (pend || clear_req) begin
                    state_n = CLEAR;
                    pend_n  = 1'b0;
                    cnt_x_n = '0;
                    cnt_y_n = '0;
                end else if (any_req) begin
                    state_n = BOX;
                    owner_n = gidx;
                    bx_n    = req.req_x[gidx*X_W +: X_W];
                    by_n    = req.req_y[gidx*Y_W +: Y_W];
                    bcol_n  = req.req_colour[gidx*C_W +: C_W];
                    bfill_n = req.req_fill[gidx];
                    ack_n   = grant;
                    ptr_n   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    cnt_x_n = '0;
                    cnt_y_n = '0;
                end
            end
            BOX: begin
                if (clear_req) pend_n = 1'b1;
                x_n      = sx[X_W-1:0];
                y_n      = sy[Y_W-1:0];
                colour_n = bcol;
                plot_n   = !clipped && (bfill || border);
                if (cnt_x == COL_LAST) begin
                    cnt_x_n = '0;
                    if (cnt_y == ROW_LAST) begin
                        done_n[owner] = 1'b1;
                        state_n       = IDLE;
                    end else begin
                        cnt_y_n = cnt_y + 1'b1;
                    end
                end else begin
                    cnt_x_n = cnt_x + 1'b1;
                end
            end
            CLEAR: begin
                x_n      = cnt_x;
                y_n      = cnt_y;
                colour_n = BG_COLOUR;
                plot_n   = 1'b1;
                if (cnt_x == X_LAST) begin
                    cnt_x_n = '0;
                    if (cnt_y == Y_LAST) state_n = IDLE;
                    else                 cnt_y_n = cnt_y + 1'b1;
                end else begin
                    cnt_x_n = cnt_x + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            pend   <= 1'b0;
            cnt_x  <= '0;
            cnt_y  <= '0;
            bx     <= '0;
            by     <= '0;
            bcol   <= '0;
            bfill  <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            ack    <= '0;
            done   <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            pend   <= pend_n;
            cnt_x  <= cnt_x_n;
            cnt_y  <= cnt_y_n;
            bx     <= bx_n;
            by     <= by_n;
            bcol   <= bcol_n;
            bfill  <= bfill_n;
            x      <= x_n;
            y      <= y_n;
            colour <= colour_n;
            plot   <= plot_n;
            busy   <= busy_n;
            ack    <= ack_n;
            done   <= done_n;
        end
    end

    assign req.req_ack  = ack;
    assign req.req_done = done;
endmodule
